// File: rtl/simon_game_ctrl.sv
// Simon memory-game sequencer.
// An 8-bit LFSR picks each new step, and the controller plays the sequence back on
// four LEDs. It then checks the player's presses one step at a time and extends the
// sequence after each completed round. The game ends in WIN when MAX_LEN steps have
// been repeated, and in LOSE on a wrong press or a timeout.
//
// state          | meaning
// ---------------+---------------------------------------------------------------
// S_IDLE         | after reset, waiting for start; LEDs dark
// S_ADD_STEP     | one cycle: append a random step, restart playback at step 0
// S_PLAY_ON      | show step idx for ON_CYCLES cycles
// S_PLAY_OFF     | dark gap of OFF_CYCLES cycles between playback steps
// S_WAIT_INPUT   | wait for the press of step idx, with a TIMEOUT_CYCLES limit
// S_WAIT_RELEASE | correct press held; echo it on the LEDs until release
// S_LOSE         | wrong press or timeout; display_loss high, score frozen
// S_WIN          | MAX_LEN rounds completed; all LEDs lit
module simon_game_ctrl #(
   parameter int         ON_CYCLES      = 25_000_000,
   parameter int         OFF_CYCLES     = 12_500_000,
   parameter int         TIMEOUT_CYCLES = 250_000_000,
   parameter int         MAX_LEN        = 9,
   parameter logic [7:0] SEED           = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] user_input,
   output logic [3:0] seq_led,
   output logic       display_loss,
   output logic [3:0] score
);

   localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int MAX_CYC    = (MAX_ON_OFF > TIMEOUT_CYCLES) ? MAX_ON_OFF : TIMEOUT_CYCLES;
   localparam int CW         = $clog2(MAX_CYC + 1);

   // Timers count down from N-1 to 0, so the terminal count marks the last cycle of N.
   localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] OFF_LOAD  = CW'(OFF_CYCLES - 1);
   localparam logic [CW-1:0] TO_LOAD   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    MAX_LEN_L = 4'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD_STEP,
      S_PLAY_ON,
      S_PLAY_OFF,
      S_WAIT_INPUT,
      S_WAIT_RELEASE,
      S_LOSE,
      S_WIN
   } state_t;

   state_t        r_state;
   logic [7:0]    r_lfsr;
   logic [1:0]    r_mem [16];
   logic [3:0]    r_len;
   logic [3:0]    r_idx;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_prev_in;
   logic [3:0]    r_seq_led;
   logic          r_display_loss;
   logic [3:0]    r_score;

   logic          w_lfsr_fb;
   logic [3:0]    w_idx_inc;
   logic          w_more_steps;
   logic [1:0]    w_first_code;
   logic [3:0]    w_cur_pat;
   logic [3:0]    w_next_pat;
   logic          w_press;
   logic          w_released;
   logic          w_cnt_done;

   assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_idx_inc    = r_idx + 4'd1;
   assign w_more_steps = (w_idx_inc < r_len);
   // In ADD_STEP of the first round, entry 0 is written on this same edge, so the LFSR
   // bits are shown directly instead of the stale array entry.
   assign w_first_code = (r_len == 4'd0) ? r_lfsr[1:0] : r_mem[0];
   assign w_cur_pat    = 4'b0001 << r_mem[r_idx];
   assign w_next_pat   = 4'b0001 << r_mem[w_idx_inc];
   assign w_press      = (user_input != 4'd0) && (r_prev_in == 4'd0);
   assign w_released   = (user_input == 4'd0);
   assign w_cnt_done   = (r_cnt == '0);

   assign seq_led      = r_seq_led;
   assign display_loss = r_display_loss;
   assign score        = r_score;

   // Step array: written only in ADD_STEP and not reset, because every entry is
   // rewritten before it is played.
   always_ff @(posedge clk) begin
      if (!rst && (r_state == S_ADD_STEP)) begin
         r_mem[r_len] <= r_lfsr[1:0];
      end
   end

   // Game FSM with its timers, LFSR, input-edge register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_lfsr         <= SEED;
         r_len          <= 4'd0;
         r_idx          <= 4'd0;
         r_cnt          <= '0;
         r_prev_in      <= 4'd0;
         r_seq_led      <= 4'd0;
         r_display_loss <= 1'b0;
         r_score        <= 4'd0;
      end else begin
         r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
         r_prev_in <= user_input;

         case (r_state)
            S_IDLE, S_LOSE, S_WIN: begin
               if (start) begin
                  r_state        <= S_ADD_STEP;
                  r_len          <= 4'd0;
                  r_score        <= 4'd0;
                  r_display_loss <= 1'b0;
                  r_seq_led      <= 4'd0;
               end
            end

            S_ADD_STEP: begin
               if (r_len < MAX_LEN_L) begin
                  r_len <= r_len + 4'd1;
               end
               r_idx     <= 4'd0;
               r_cnt     <= ON_LOAD;
               r_seq_led <= 4'b0001 << w_first_code;
               r_state   <= S_PLAY_ON;
            end

            S_PLAY_ON: begin
               if (w_cnt_done) begin
                  r_cnt     <= OFF_LOAD;
                  r_seq_led <= 4'd0;
                  r_state   <= S_PLAY_OFF;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_PLAY_OFF: begin
               if (w_cnt_done) begin
                  if (w_more_steps) begin
                     r_idx     <= w_idx_inc;
                     r_cnt     <= ON_LOAD;
                     r_seq_led <= w_next_pat;
                     r_state   <= S_PLAY_ON;
                  end else begin
                     r_idx   <= 4'd0;
                     r_cnt   <= TO_LOAD;
                     r_state <= S_WAIT_INPUT;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_WAIT_INPUT: begin
               if (w_press) begin
                  if (user_input == w_cur_pat) begin
                     r_seq_led <= user_input;
                     r_state   <= S_WAIT_RELEASE;
                  end else begin
                     r_display_loss <= 1'b1;
                     r_seq_led      <= 4'd0;
                     r_state        <= S_LOSE;
                  end
               end else if (w_cnt_done) begin
                  r_display_loss <= 1'b1;
                  r_seq_led      <= 4'd0;
                  r_state        <= S_LOSE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_WAIT_RELEASE: begin
               if (w_released) begin
                  r_seq_led <= 4'd0;
                  if (w_more_steps) begin
                     r_idx   <= w_idx_inc;
                     r_cnt   <= TO_LOAD;
                     r_state <= S_WAIT_INPUT;
                  end else begin
                     if (r_score < MAX_LEN_L) begin
                        r_score <= r_score + 4'd1;
                     end
                     if (r_len >= MAX_LEN_L) begin
                        r_seq_led <= 4'b1111;
                        r_state   <= S_WIN;
                     end else begin
                        r_state <= S_ADD_STEP;
                     end
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
